// File: rtl/mean_batch_loader.sv
// rtl/mean_batch_loader.sv - fills a DEPTH-entry buffer from a byte stream, launches the mean unit and checks its result
module mean_batch_loader #(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 32,
  parameter int START_CYCLES = 2,
  parameter int TIMEOUT      = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] data_mem [1:DEPTH],
  input  logic             calc_ready,
  input  logic             calc_done,
  input  logic [WIDTH-1:0] calc_mean,
  output logic             start,
  output logic             busy,
  output logic [WIDTH-1:0] mean_out,
  output logic             mean_valid,
  output logic             mismatch,
  output logic             timeout
);

  localparam int LOG2_D = $clog2(DEPTH);
  localparam int SUM_W  = WIDTH + LOG2_D;
  localparam int IDX_W  = $clog2(DEPTH + 1);
  localparam int SC_W   = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
  localparam int TO_W   = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_FILL      = 2'd0;
  localparam logic [1:0] S_LAUNCH    = 2'd1;
  localparam logic [1:0] S_START     = 2'd2;
  localparam logic [1:0] S_WAIT_DONE = 2'd3;

  logic [1:0]       state;
  logic [IDX_W-1:0] wr_idx;
  logic [SUM_W-1:0] sum;
  logic [SC_W-1:0]  st_cnt;
  logic [TO_W-1:0]  wait_cnt;
  logic [WIDTH-1:0] ref_mean;

  // sum cannot overflow, so the floor mean is just the upper bits
  assign ref_mean = sum[SUM_W-1:LOG2_D];

  assign in_ready = (state == S_FILL) && !rst;
  assign start    = (state == S_START);
  assign busy     = (state != S_FILL);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_FILL;
      wr_idx     <= IDX_W'(1);
      sum        <= '0;
      st_cnt     <= '0;
      wait_cnt   <= '0;
      mean_out   <= '0;
      mean_valid <= 1'b0;
      mismatch   <= 1'b0;
      timeout    <= 1'b0;
      for (int i = 1; i <= DEPTH; i++) begin
        data_mem[i] <= '0;
      end
    end else begin
      mean_valid <= 1'b0;
      case (state)
        S_FILL: begin
          if (in_valid) begin
            data_mem[wr_idx] <= in_data;
            sum              <= sum + SUM_W'(in_data);
            wr_idx           <= wr_idx + IDX_W'(1);
            if (wr_idx == IDX_W'(DEPTH)) begin
              state <= S_LAUNCH;
            end
          end
        end
        S_LAUNCH: begin
          st_cnt <= '0;
          if (calc_ready) begin
            state <= S_START;
          end
        end
        S_START: begin
          st_cnt <= st_cnt + SC_W'(1);
          if (st_cnt == SC_W'(START_CYCLES - 1)) begin
            state    <= S_WAIT_DONE;
            wait_cnt <= '0;
          end
        end
        S_WAIT_DONE: begin
          wait_cnt <= wait_cnt + TO_W'(1);
          if (calc_done) begin
            mean_out   <= calc_mean;
            mean_valid <= 1'b1;
            mismatch   <= (calc_mean != ref_mean);
            timeout    <= 1'b0;
            state      <= S_FILL;
            wr_idx     <= IDX_W'(1);
            sum        <= '0;
          end else if (wait_cnt == TO_W'(TIMEOUT - 1)) begin
            // no result to compare, so a timeout also retires the previous mismatch
            timeout  <= 1'b1;
            mismatch <= 1'b0;
            state    <= S_FILL;
            wr_idx   <= IDX_W'(1);
            sum      <= '0;
          end
        end
        default: state <= S_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_mean_batch_loader.sv
// tb/tb_mean_batch_loader.sv - directed bench with a batch-level reference model for mean_batch_loader
module tb_mean_batch_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready;
  logic [7:0] data_mem [1:32];
  logic       calc_ready = 1'b0;
  logic       calc_done = 1'b0;
  logic [7:0] calc_mean = '0;
  logic       start, busy, mean_valid, mismatch, timeout;
  logic [7:0] mean_out;

  always #5 clk = ~clk;

  mean_batch_loader dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .data_mem(data_mem), .calc_ready(calc_ready), .calc_done(calc_done), .calc_mean(calc_mean),
    .start(start), .busy(busy), .mean_out(mean_out), .mean_valid(mean_valid),
    .mismatch(mismatch), .timeout(timeout)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Batch-level model: phase 0 fill, 1 awaiting mean unit, 2 start pulse, 3 awaiting result
  int         ph = 0;
  int         fill_n = 0;
  int         st_left = 0;
  int         waited = 0;
  logic [7:0] m_mem [1:32];
  logic [7:0] m_mean = '0;
  bit         m_mv = 0, m_mis = 0, m_to = 0;
  bit         chk_en = 0;

  always @(posedge clk) begin
    m_mv = 0;
    if (rst) begin
      ph = 0; fill_n = 0; m_mean = '0; m_mis = 0; m_to = 0;
      for (int i = 1; i <= 32; i++) m_mem[i] = '0;
    end else begin
      case (ph)
        0: if (in_valid) begin
          fill_n++;
          m_mem[fill_n] = in_data;
          if (fill_n == 32) ph = 1;
        end
        1: if (calc_ready) begin ph = 2; st_left = 2; end
        2: begin
          st_left--;
          if (st_left == 0) begin ph = 3; waited = 0; end
        end
        default: begin
          if (calc_done) begin
            int s;
            s = 0;
            for (int i = 1; i <= 32; i++) s += m_mem[i];
            m_mean = calc_mean; m_mv = 1; m_mis = (calc_mean != s / 32); m_to = 0;
            ph = 0; fill_n = 0;
          end else begin
            waited++;
            if (waited == 256) begin m_to = 1; m_mis = 0; ph = 0; fill_n = 0; end
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int e;
      chk("in_ready", in_ready, (ph == 0) && !rst);
      chk("start", start, ph == 2);
      chk("busy", busy, ph != 0);
      chk("mean_out", mean_out, m_mean);
      chk("mean_valid", mean_valid, m_mv);
      chk("mismatch", mismatch, m_mis);
      chk("timeout", timeout, m_to);
      e = 0;
      for (int i = 1; i <= 32; i++) if (data_mem[i] !== m_mem[i] && e == 0) e = i;
      chk("data_mem_first_bad_index", e, 0);
    end
  end

  logic [7:0] vals [1:32];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int n, input int gap);
    for (int k = 1; k <= n; k++) begin
      int guard;
      bit ok;
      guard = 0;
      in_valid = 1'b1;
      in_data = vals[k];
      do begin
        ok = in_ready;
        step();
        guard++;
      end while (!ok && guard < 100);
      if (!ok) chk("feed_accept_timeout", 0, 1);
      in_valid = 1'b0;
      for (int g = 0; g < gap; g++) step();
    end
  endtask

  task automatic launch(output int c);
    int g;
    g = 0;
    c = 0;
    while (!start && g < 50) begin step(); g++; end
    while (start && c < 20) begin c++; step(); end
  endtask

  task automatic respond(input logic [7:0] m);
    calc_mean = m;
    calc_done = 1'b1;
    step();
    calc_done = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int c, n, errs;
    step();
    chk_en = 1;
    step();
    chk("reset_in_ready", in_ready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_start", start, 0);
    chk("reset_mean_out", mean_out, 0);
    chk("reset_flags", {mean_valid, mismatch, timeout}, 0);
    rst = 1'b0;
    #1;
    chk("post_reset_in_ready", in_ready, 1);

    // 1: constant batch, immediate launch
    calc_ready = 1'b1;
    for (int k = 1; k <= 32; k++) vals[k] = 8'd10;
    feed(32, 0);
    chk("t1_launch_busy", busy, 1);
    chk("t1_launch_start", start, 0);
    step(); chk("t1_start_c1", start, 1);
    step(); chk("t1_start_c2", start, 1);
    step(); chk("t1_start_drop", start, 0);
    respond(8'd10);
    chk("t1_mean_valid", mean_valid, 1);
    chk("t1_mean_out", mean_out, 10);
    chk("t1_mismatch", mismatch, 0);
    step();
    chk("t1_mean_valid_pulse", mean_valid, 0);

    // 2: ramp 1..32, sum 528 -> floor mean 16
    for (int k = 1; k <= 32; k++) vals[k] = 8'(k);
    feed(32, 0);
    launch(c);
    chk("t2_start_cycles", c, 2);
    respond(8'd17);
    chk("t2_mismatch_set", mismatch, 1);
    chk("t2_mean_out", mean_out, 17);
    chk("t2_model_mismatch", m_mis, 1);
    feed(32, 0);
    launch(c);
    respond(8'd16);
    chk("t2_mismatch_clear", mismatch, 0);

    // 3: gapped input, sum 1808 -> 56
    for (int k = 1; k <= 32; k++) vals[k] = 8'(3 * k + 7);
    feed(32, 1);
    chk("t3_busy_after_32", busy, 1);
    errs = 0;
    for (int k = 1; k <= 32; k++) if (data_mem[k] !== 8'(3 * k + 7)) errs++;
    chk("t3_mem_contents", errs, 0);
    launch(c);
    respond(8'd56);
    chk("t3_mismatch", mismatch, 0);

    // 4: mean unit not ready for 10 cycles
    calc_ready = 1'b0;
    for (int k = 1; k <= 32; k++) vals[k] = 8'd20;
    feed(32, 0);
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (start !== 1'b0 || busy !== 1'b1) errs++;
    end
    chk("t4_hold_launch", errs, 0);
    calc_ready = 1'b1;
    step(); chk("t4_start_c1", start, 1);
    step(); chk("t4_start_c2", start, 1);
    step(); chk("t4_start_drop", start, 0);
    respond(8'd20);
    chk("t4_mean_out", mean_out, 20);

    // 5: no calc_done -> timeout after 256 cycles
    for (int k = 1; k <= 32; k++) vals[k] = 8'd50;
    feed(32, 0);
    launch(c);
    n = 0;
    while (busy && n < 400) begin step(); n++; end
    chk("t5_wait_cycles", n, 256);
    chk("t5_timeout", timeout, 1);
    chk("t5_in_ready", in_ready, 1);
    chk("t5_mean_out_kept", mean_out, 20);

    // 6: reset mid-fill, stray calc_done during fill, sum 3728 -> 116
    for (int k = 1; k <= 32; k++) vals[k] = 8'(k);
    feed(10, 0);
    rst = 1'b1;
    #1;
    chk("t6_reset_in_ready", in_ready, 0);
    step();
    rst = 1'b0;
    #1;
    errs = 0;
    for (int k = 1; k <= 32; k++) if (data_mem[k] !== 8'd0) errs++;
    chk("t6_mem_cleared", errs, 0);
    chk("t6_in_ready", in_ready, 1);
    chk("t6_timeout_cleared", timeout, 0);
    respond(8'd99);
    chk("t6_stray_done_valid", mean_valid, 0);
    chk("t6_stray_done_mean", mean_out, 0);
    for (int k = 1; k <= 32; k++) vals[k] = 8'(k + 100);
    feed(32, 0);
    launch(c);
    respond(8'd116);
    chk("t6_mean_out", mean_out, 116);
    chk("t6_mismatch", mismatch, 0);
    step();

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
